// File: rtl/trace_sequencer.sv
// Sequencing controller for the single-step x86 core: feeds trace steps to the core
// one at a time and checks each step's pre-state against the previous step's post-state.
module trace_sequencer #(
    parameter int          STEP_W     = 560,
    parameter logic [31:0] FLAGS_MASK = 32'h0000_08D5,
    parameter int          CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step_valid,
    output logic              step_ready,
    input  logic [STEP_W-1:0] step,
    input  logic              step_last,
    output logic [STEP_W-1:0] core_step,
    input  logic [319:0]      core_regs,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [CNT_W-1:0]  step_count,
    output logic [3:0]        fail_reg
);

    localparam int NREG = 10;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        EXEC,
        DONE,
        FAIL
    } state_t;

    state_t       state;
    logic [319:0] exp_q;
    logic         have_exp;
    logic         last_q;

    logic [319:0] pre_state;
    logic         handshake;
    logic         mismatch;
    logic [3:0]   mismatch_idx;

    assign pre_state = step[463:144];
    assign handshake = step_valid & step_ready;

    // Scan from the top register down so the lowest mismatching index wins.
    always_comb begin
        mismatch     = 1'b0;
        mismatch_idx = 4'd0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (((pre_state[319-32*i -: 32] ^ exp_q[319-32*i -: 32]) &
                 ((i == NREG - 1) ? FLAGS_MASK : 32'hFFFF_FFFF)) != 32'd0) begin
                mismatch     = have_exp;
                mismatch_idx = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            step_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            step_count <= '0;
            fail_reg   <= 4'd0;
            core_step  <= '0;
            exp_q      <= '0;
            have_exp   <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        state      <= ACCEPT;
                        step_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        step_count <= '0;
                        fail_reg   <= 4'd0;
                        have_exp   <= 1'b0;
                    end
                end

                // A failing step is consumed but never reaches the core.
                ACCEPT: begin
                    if (handshake) begin
                        step_ready <= 1'b0;
                        if (mismatch) begin
                            state    <= FAIL;
                            busy     <= 1'b0;
                            fail     <= 1'b1;
                            fail_reg <= mismatch_idx;
                        end else begin
                            state     <= EXEC;
                            core_step <= step;
                            last_q    <= step_last;
                        end
                    end
                end

                EXEC: begin
                    exp_q    <= core_regs;
                    have_exp <= 1'b1;
                    if (step_count != {CNT_W{1'b1}}) begin
                        step_count <= step_count + CNT_W'(1);
                    end
                    if (last_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state      <= ACCEPT;
                        step_ready <= 1'b1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    step_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_sequencer.sv
// Directed bench for trace_sequencer: a small core model drives core_regs, and a
// scoreboard holds expected core_step values and expected end-of-trace results.
module tb_trace_sequencer;

    localparam int STEP_W = 560;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              step_valid = 1'b0;
    logic              step_ready;
    logic [STEP_W-1:0] step = '0;
    logic              step_last = 1'b0;
    logic [STEP_W-1:0] core_step;
    logic [319:0]      core_regs;
    logic              busy;
    logic              done;
    logic              fail;
    logic [CNT_W-1:0]  step_count;
    logic [3:0]        fail_reg;

    trace_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .step_valid (step_valid),
        .step_ready (step_ready),
        .step       (step),
        .step_last  (step_last),
        .core_step  (core_step),
        .core_regs  (core_regs),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .step_count (step_count),
        .fail_reg   (fail_reg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        done;
        logic        fail;
        logic [3:0]  fail_reg;
        logic [31:0] count;
    } result_t;

    result_t           result_q[$];
    logic [STEP_W-1:0] core_q[$];

    int compared   = 0;
    int mismatched = 0;

    logic [319:0] m_exp = '0;
    bit           m_have_exp = 1'b0;
    int           m_count = 0;

    function automatic logic [31:0] get_reg(input logic [319:0] p, input int i);
        return p[319-32*i -: 32];
    endfunction

    function automatic logic [319:0] set_reg(input logic [319:0] p, input int i, input logic [31:0] v);
        logic [319:0] r;
        r = p;
        r[319-32*i -: 32] = v;
        return r;
    endfunction

    // Toy core: eax += 1, eip += 3 (a 3-byte instruction), eflags becomes 0x2.
    function automatic logic [319:0] core_fn(input logic [319:0] pre);
        logic [319:0] post;
        post = set_reg(pre, 0, get_reg(pre, 0) + 32'd1);
        post = set_reg(post, 8, get_reg(pre, 8) + 32'd3);
        post = set_reg(post, 9, 32'h0000_0002);
        return post;
    endfunction

    function automatic int first_mismatch(input logic [319:0] pre, input logic [319:0] exp);
        int          idx;
        logic [31:0] mask;
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            mask = (i == 9) ? 32'h0000_08D5 : 32'hFFFF_FFFF;
            if (idx < 0 && ((get_reg(pre, i) ^ get_reg(exp, i)) & mask) != 32'd0) idx = i;
        end
        return idx;
    endfunction

    assign core_regs = core_fn(core_step[463:144]);

    task automatic checkOutput(input string tag, input logic [STEP_W-1:0] obs, input logic [STEP_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        compared++;
        mismatched++;
        $error("[TB] FAIL %s: observed timeout expected event", tag);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_have_exp = 1'b0;
        m_count = 0;
    endtask

    // Offers one step, records the handshake cycle and updates the model/scoreboard.
    task automatic applyStimulus(input logic [319:0] pre, input logic last, output int hs_cyc);
        int                n;
        int                mism;
        logic [STEP_W-1:0] s;
        logic [STEP_W-1:0] exp_step;
        s = {96'hC0DE_0F0B_1234_5678_9ABC_DEF0, pre, 72'hAA_BBBB_CCCC_DDDD_EEEE, 72'h55_6666_7777_8888_9999};
        step = s;
        step_last = last;
        step_valid = 1'b1;
        n = 0;
        hs_cyc = -1;
        while (!step_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!step_ready) begin
            timeout_fail("handshake");
            step_valid = 1'b0;
        end else begin
            hs_cyc = cyc;
            mism = m_have_exp ? first_mismatch(pre, m_exp) : -1;
            if (mism >= 0) begin
                result_q.push_back('{1'b0, 1'b1, 4'(mism), 32'(m_count)});
            end else begin
                core_q.push_back(s);
                m_exp = core_fn(pre);
                m_have_exp = 1'b1;
                m_count++;
                if (last) result_q.push_back('{1'b1, 1'b0, 4'd0, 32'(m_count)});
            end
            @(negedge clk);
            step_valid = 1'b0;
            step_last = 1'b0;
            for (int k = 0; k < STEP_W / 32; k++) step[32*k +: 32] = $urandom;
            if (mism < 0) begin
                exp_step = core_q.pop_front();
                checkOutput("core_step", core_step, exp_step);
            end
        end
    endtask

    task automatic wait_end(input string tag);
        int      n;
        result_t r;
        n = 0;
        while (!(done || fail) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(done || fail) || result_q.size() == 0) begin
            timeout_fail({tag, "_end"});
        end else begin
            r = result_q.pop_front();
            checkOutput({tag, "_done"}, STEP_W'(done), STEP_W'(r.done));
            checkOutput({tag, "_fail"}, STEP_W'(fail), STEP_W'(r.fail));
            checkOutput({tag, "_fail_reg"}, STEP_W'(fail_reg), STEP_W'(r.fail_reg));
            checkOutput({tag, "_count"}, STEP_W'(step_count), STEP_W'(r.count));
        end
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_ready"}, STEP_W'(step_ready), '0);
        checkOutput({tag, "_busy"}, STEP_W'(busy), '0);
        checkOutput({tag, "_done"}, STEP_W'(done), '0);
        checkOutput({tag, "_fail"}, STEP_W'(fail), '0);
        checkOutput({tag, "_count"}, STEP_W'(step_count), '0);
        checkOutput({tag, "_fail_reg"}, STEP_W'(fail_reg), '0);
        checkOutput({tag, "_core_step"}, core_step, '0);
    endtask

    logic [319:0] pre0, pre1, p;
    int           h;
    int           hc[4];

    initial begin
        $display("[TB] trace_sequencer bench start");
        pre0 = set_reg(set_reg(set_reg('0, 0, 32'd1), 8, 32'h0000_1000), 6, 32'h0000_0FFC);
        pre1 = set_reg(set_reg(set_reg(set_reg('0, 0, 32'd2), 8, 32'h0000_1003), 9, 32'h0000_0002), 6, 32'h0000_0FFC);

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // No start: the sequencer must not accept steps.
        step_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_ready", STEP_W'(step_ready), '0);
        step_valid = 1'b0;

        // Two-step chain that passes.
        pulseStart();
        checkOutput("accept_ready", STEP_W'(step_ready), STEP_W'(1'b1));
        applyStimulus(pre0, 1'b0, h);
        checkOutput("exec_busy", STEP_W'(busy), STEP_W'(1'b1));
        checkOutput("exec_ready", STEP_W'(step_ready), '0);
        checkOutput("exec_count_old", STEP_W'(step_count), '0);
        applyStimulus(pre1, 1'b1, h);
        wait_end("chain");

        // esp and ebx both differ; ebx is the lowest index.
        pulseStart();
        applyStimulus(pre0, 1'b0, h);
        applyStimulus(set_reg(set_reg(pre1, 6, 32'h0000_1000), 1, 32'd5), 1'b1, h);
        wait_end("mismatch");

        // IF (bit 9) is outside the compare mask.
        pulseStart();
        applyStimulus(pre0, 1'b0, h);
        applyStimulus(set_reg(pre1, 9, 32'h0000_0202), 1'b1, h);
        wait_end("flag_if");

        // CF (bit 0) is inside the compare mask.
        pulseStart();
        applyStimulus(pre0, 1'b0, h);
        applyStimulus(set_reg(pre1, 9, 32'h0000_0003), 1'b1, h);
        wait_end("flag_cf");

        // Restart from FAIL: first step is never compared.
        pulseStart();
        checkOutput("restart_fail", STEP_W'(fail), '0);
        checkOutput("restart_count", STEP_W'(step_count), '0);
        p = '0;
        for (int k = 0; k < 10; k++) p = set_reg(p, k, $urandom);
        applyStimulus(p, 1'b1, h);
        wait_end("restart");

        // Continuous valid: one handshake every two cycles.
        pulseStart();
        p = pre0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(p, (k == 3), hc[k]);
            if (k > 0) checkOutput("hs_gap", STEP_W'(hc[k] - hc[k-1]), STEP_W'(2));
            p = core_fn(p);
        end
        wait_end("throughput");

        // Valid low for 3 cycles while waiting in ACCEPT.
        pulseStart();
        applyStimulus(pre0, 1'b0, h);
        @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("stall_ready", STEP_W'(step_ready), STEP_W'(1'b1));
        checkOutput("stall_busy", STEP_W'(busy), STEP_W'(1'b1));
        checkOutput("stall_count", STEP_W'(step_count), STEP_W'(1));
        applyStimulus(pre1, 1'b1, h);
        wait_end("stall");

        // Asynchronous reset in the middle of EXEC.
        pulseStart();
        applyStimulus(pre0, 1'b0, h);
        checkOutput("pre_rst_busy", STEP_W'(busy), STEP_W'(1'b1));
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        m_have_exp = 1'b0;
        m_count = 0;
        @(negedge clk);
        checkOutput("post_rst_ready", STEP_W'(step_ready), '0);

        checkOutput("queues_empty", STEP_W'(result_q.size() + core_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
